// File: rtl/jtkunio_gfxrom_arb.sv
// Graphics ROM arbiter for the kunio video stage.
// Three fetch clients (char, scroll, object) share one 32-bit SDRAM read
// port. Each client has a one-word cache (tag, valid, data). The ok flags
// are combinational hit checks against the client's current address.
// Misses are served one at a time with fixed priority char > scr > obj.
// Optional fill statistics are enabled with the JTKUNIO_GFXSTATS_EN macro.
//
// SDRAM handshake: sdram_req is raised together with a stable sdram_addr
// and held until sdram_ack (a one-cycle pulse) accepts the request.
// sdram_dok (a one-cycle pulse) then qualifies sdram_din. It may coincide
// with the ack. ack/dok pulses arriving while IDLE are ignored.
module jtkunio_gfxrom_arb #(
    parameter logic [21:0] CHAR_OFFSET = 22'h00000,
    parameter logic [21:0] SCR_OFFSET  = 22'h04000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h24000
) (
    input  logic        clk,
    input  logic        rst,
`ifdef JTKUNIO_GFXSTATS_EN
    input  logic        stat_clr,
    output logic [15:0] stat_char,
    output logic [15:0] stat_scr,
    output logic [15:0] stat_obj,
`endif
    input  logic [13:0] char_addr,
    output logic [31:0] char_data,
    output logic        char_ok,
    input  logic [16:0] scr_addr,
    output logic [31:0] scr_data,
    output logic        scr_ok,
    input  logic        obj_cs,
    input  logic [17:0] obj_addr,
    output logic [31:0] obj_data,
    output logic        obj_ok,
    output logic [21:0] sdram_addr,
    output logic        sdram_req,
    input  logic        sdram_ack,
    input  logic        sdram_dok,
    input  logic [31:0] sdram_din
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    localparam logic [1:0] SLOT_C = 2'd0;
    localparam logic [1:0] SLOT_S = 2'd1;
    localparam logic [1:0] SLOT_O = 2'd2;

    // FSM state, kept as a named signal so checkers can bind to it
    state_t      state;
    state_t      state_nx;

    // Per-client cache
    logic [13:0] tag_c;
    logic [16:0] tag_s;
    logic [17:0] tag_o;
    logic        valid_c;
    logic        valid_s;
    logic        valid_o;

    // Transaction in flight
    logic [1:0]  slot;
    logic [17:0] pend_tag;

    // Hit / miss and arbitration results
    logic        hit_c;
    logic        hit_s;
    logic        hit_o;
    logic        miss_c;
    logic        miss_s;
    logic        miss_o;
    logic        any_miss;
    logic [1:0]  win_slot;
    logic [17:0] win_tag;
    logic [21:0] win_addr;

    // FSM actions
    logic        issue;
    logic        drop_req;
    logic        fill;

    // Object hit ignores obj_cs; obj_cs only gates the flag and the miss
    assign hit_c    = valid_c & (char_addr == tag_c);
    assign hit_s    = valid_s & (scr_addr == tag_s);
    assign hit_o    = valid_o & (obj_addr == tag_o);
    assign miss_c   = ~hit_c;
    assign miss_s   = ~hit_s;
    assign miss_o   = obj_cs & ~hit_o;
    assign any_miss = miss_c | miss_s | miss_o;

    assign char_ok  = hit_c;
    assign scr_ok   = hit_s;
    assign obj_ok   = obj_cs & hit_o;

    // Fixed-priority winner selection and SDRAM address for it
    always_comb begin
        win_slot = SLOT_C;
        win_tag  = {4'd0, char_addr};
        win_addr = CHAR_OFFSET + {8'd0, char_addr};
        if (miss_c) begin
            win_slot = SLOT_C;
            win_tag  = {4'd0, char_addr};
            win_addr = CHAR_OFFSET + {8'd0, char_addr};
        end else if (miss_s) begin
            win_slot = SLOT_S;
            win_tag  = {1'b0, scr_addr};
            win_addr = SCR_OFFSET + {5'd0, scr_addr};
        end else if (miss_o) begin
            win_slot = SLOT_O;
            win_tag  = obj_addr;
            win_addr = OBJ_OFFSET + {4'd0, obj_addr};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FSM next-state logic; ack together with dok finishes immediately
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (any_miss) state_nx = WAIT_ACK;
            WAIT_ACK: begin
                if (sdram_ack && sdram_dok) state_nx = IDLE;
                else if (sdram_ack)         state_nx = WAIT_DATA;
            end
            WAIT_DATA: if (sdram_dok) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // FSM output decode: request issue, request drop and cache fill strobes
    always_comb begin
        issue    = 1'b0;
        drop_req = 1'b0;
        fill     = 1'b0;
        case (state)
            IDLE:      issue = any_miss;
            WAIT_ACK: begin
                drop_req = sdram_ack;
                fill     = sdram_ack & sdram_dok;
            end
            WAIT_DATA: fill = sdram_dok;
            default: ;
        endcase
    end

    // Request register, pending transaction and per-client cache update
    always_ff @(posedge clk) begin
        if (rst) begin
            sdram_req  <= 1'b0;
            sdram_addr <= 22'd0;
            slot       <= SLOT_C;
            pend_tag   <= 18'd0;
            valid_c    <= 1'b0;
            valid_s    <= 1'b0;
            valid_o    <= 1'b0;
            tag_c      <= 14'd0;
            tag_s      <= 17'd0;
            tag_o      <= 18'd0;
            char_data  <= 32'd0;
            scr_data   <= 32'd0;
            obj_data   <= 32'd0;
        end else begin
            if (issue) begin
                sdram_req  <= 1'b1;
                sdram_addr <= win_addr;
                slot       <= win_slot;
                pend_tag   <= win_tag;
                // The slot goes invalid at issue so an old word is never ok
                case (win_slot)
                    SLOT_C:  valid_c <= 1'b0;
                    SLOT_S:  valid_s <= 1'b0;
                    default: valid_o <= 1'b0;
                endcase
            end
            if (drop_req) sdram_req <= 1'b0;
            if (fill) begin
                case (slot)
                    SLOT_C: begin
                        char_data <= sdram_din;
                        tag_c     <= pend_tag[13:0];
                        valid_c   <= 1'b1;
                    end
                    SLOT_S: begin
                        scr_data <= sdram_din;
                        tag_s    <= pend_tag[16:0];
                        valid_s  <= 1'b1;
                    end
                    default: begin
                        obj_data <= sdram_din;
                        tag_o    <= pend_tag;
                        valid_o  <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef JTKUNIO_GFXSTATS_EN
    // Saturating per-client fill counters
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_char <= 16'd0;
            stat_scr  <= 16'd0;
            stat_obj  <= 16'd0;
        end else if (fill) begin
            case (slot)
                SLOT_C:  if (stat_char != 16'hFFFF) stat_char <= stat_char + 16'd1;
                SLOT_S:  if (stat_scr  != 16'hFFFF) stat_scr  <= stat_scr  + 16'd1;
                default: if (stat_obj  != 16'hFFFF) stat_obj  <= stat_obj  + 16'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_jtkunio_gfxrom_arb.sv
// Testbench for jtkunio_gfxrom_arb: directed scenarios followed by random
// traffic, checked every cycle against a cache/transaction model of the
// arbiter plus an SDRAM responder with configurable ack/dok delays.
module tb_jtkunio_gfxrom_arb;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [13:0] char_addr;
    logic [31:0] char_data;
    logic        char_ok;
    logic [16:0] scr_addr;
    logic [31:0] scr_data;
    logic        scr_ok;
    logic        obj_cs;
    logic [17:0] obj_addr;
    logic [31:0] obj_data;
    logic        obj_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        sdram_dok;
    logic [31:0] sdram_din;
`ifdef JTKUNIO_GFXSTATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_char;
    logic [15:0] stat_scr;
    logic [15:0] stat_obj;
`endif

    jtkunio_gfxrom_arb dut (
        .clk        (clk),
        .rst        (rst),
`ifdef JTKUNIO_GFXSTATS_EN
        .stat_clr   (stat_clr),
        .stat_char  (stat_char),
        .stat_scr   (stat_scr),
        .stat_obj   (stat_obj),
`endif
        .char_addr  (char_addr),
        .char_data  (char_data),
        .char_ok    (char_ok),
        .scr_addr   (scr_addr),
        .scr_data   (scr_data),
        .scr_ok     (scr_ok),
        .obj_cs     (obj_cs),
        .obj_addr   (obj_addr),
        .obj_data   (obj_data),
        .obj_ok     (obj_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .sdram_dok  (sdram_dok),
        .sdram_din  (sdram_din)
    );

    // ---------------- scoreboard / model state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [17:0] m_tag [3];
    bit          m_val [3];
    logic [31:0] m_dat [3];

    int          phase;       // 0 idle, 1 request outstanding, 2 waiting data
    int          ack_cnt;
    int          dok_cnt;
    int          pend;
    logic [17:0] pend_tag;
    logic [21:0] pend_addr;
    bit          exp_req;
    int          force_ack  = -1;
    int          force_dok  = -1;
    bit          force_spur = 1'b0;
    bit          prev_req   = 1'b0;
    logic [21:0] got_q[$];    // request addresses observed from the DUT

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] caddr(int i);
        case (i)
            0:       return {4'd0, char_addr};
            1:       return {1'b0, scr_addr};
            default: return obj_addr;
        endcase
    endfunction

    function automatic logic [21:0] coff(int i);
        case (i)
            0:       return 22'h00000;
            1:       return 22'h04000;
            default: return 22'h24000;
        endcase
    endfunction

    function automatic bit m_hit(int i);
        return m_val[i] && (m_tag[i] == caddr(i)) && (i != 2 || obj_cs);
    endfunction

    function automatic bit m_miss(int i);
        if (i == 2) return obj_cs && !(m_val[2] && (m_tag[2] == caddr(2)));
        return !m_hit(i);
    endfunction

    // ROM contents seen through the SDRAM port
    function automatic logic [31:0] mem(logic [21:0] a);
        if (a == 22'h000010) return 32'hDEADBEEF;
        return {a[9:0], a} ^ 32'hA5C3_0F96;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_val[i] = 1'b0;
            m_tag[i] = 18'd0;
            m_dat[i] = 32'd0;
        end
        phase   = 0;
        exp_req = 1'b0;
    endtask

    task automatic do_fill();
        m_val[pend] = 1'b1;
        m_tag[pend] = pend_tag;
        m_dat[pend] = mem(pend_addr);
        sdram_dok   = 1'b1;
        sdram_din   = mem(pend_addr);
    endtask

    // Compare all DUT outputs against the model (called between edges)
    task automatic check_outputs();
        check("sdram_req", {31'd0, sdram_req}, {31'd0, exp_req});
        if (exp_req) check("sdram_addr", {10'd0, sdram_addr}, {10'd0, pend_addr});
        check("char_ok", {31'd0, char_ok}, {31'd0, m_hit(0)});
        check("scr_ok", {31'd0, scr_ok}, {31'd0, m_hit(1)});
        check("obj_ok", {31'd0, obj_ok}, {31'd0, m_hit(2)});
        check("char_data", char_data, m_dat[0]);
        check("scr_data", scr_data, m_dat[1]);
        check("obj_data", obj_data, m_dat[2]);
        if (sdram_req && !prev_req) got_q.push_back(sdram_addr);
        prev_req = sdram_req;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst       = 1'b1;
        sdram_ack = 1'b0;
        sdram_dok = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check_outputs();
    endtask

    // Drive SDRAM pulses for the next edge, predict its effect, then check
    task automatic advance();
        int win;
        int d;
        sdram_ack = 1'b0;
        sdram_dok = 1'b0;
        sdram_din = $urandom;
        case (phase)
            0: begin
                // Stray pulses while idle must be ignored
                if (force_spur || $urandom_range(0, 15) == 0) sdram_dok = 1'b1;
                if ($urandom_range(0, 15) == 0) sdram_ack = 1'b1;
                win = -1;
                for (int i = 0; i < 3; i++)
                    if (win < 0 && m_miss(i)) win = i;
                if (win >= 0) begin
                    pend       = win;
                    pend_tag   = caddr(win);
                    pend_addr  = coff(win) + {4'd0, caddr(win)};
                    m_val[win] = 1'b0;
                    phase      = 1;
                    ack_cnt    = (force_ack >= 0) ? force_ack : $urandom_range(0, 3);
                    exp_req    = 1'b1;
                end else begin
                    exp_req = 1'b0;
                end
            end
            1: begin
                if (ack_cnt == 0) begin
                    sdram_ack = 1'b1;
                    exp_req   = 1'b0;
                    d = (force_dok >= 0) ? force_dok : $urandom_range(0, 3);
                    if (d == 0) begin
                        do_fill();
                        phase = 0;
                    end else begin
                        dok_cnt = d;
                        phase   = 2;
                    end
                end else begin
                    ack_cnt--;
                    exp_req = 1'b1;
                end
            end
            default: begin
                if (dok_cnt <= 1) begin
                    do_fill();
                    phase = 0;
                end else begin
                    dok_cnt--;
                end
            end
        endcase
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) advance();
    endtask

    task automatic run_until_phase(int p);
        int n = 0;
        while (phase != p && n < 30) begin
            advance();
            n++;
        end
        check("wait_bound", {31'd0, (phase == p)}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        char_addr = 14'h0010;
        scr_addr  = 17'h00000;
        obj_addr  = 18'h00000;
        obj_cs    = 1'b0;
        sdram_din = 32'd0;
        do_reset();

        // Single char miss with a slow SDRAM
        force_ack = 1;
        force_dok = 3;
        run(30);
        check("t1_addr", {10'd0, got_q[0]}, 32'h000010);
        check("t1_data", char_data, 32'hDEADBEEF);
        check("t1_ok", {31'd0, char_ok}, 32'd1);
        cnt = 0;
        foreach (got_q[i]) if (got_q[i] == 22'h000010) cnt++;
        check("t1_single_req", cnt, 1);

        // All three clients miss together
        force_ack = -1;
        force_dok = -1;
        char_addr = 14'h0022;
        scr_addr  = 17'h00100;
        obj_addr  = 18'h00020;
        obj_cs    = 1'b1;
        do_reset();
        got_q.delete();
        run(40);
        check("t2_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("t2_char", {10'd0, got_q[0]}, 32'h000022);
            check("t2_scr", {10'd0, got_q[1]}, 32'h004100);
            check("t2_obj", {10'd0, got_q[2]}, 32'h024020);
        end

        // Char address moves while waiting for data
        got_q.delete();
        char_addr = 14'h0010;
        force_ack = 0;
        force_dok = 4;
        run_until_phase(2);
        char_addr = 14'h0011;
        run(30);
        check("t3_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t3_first", {10'd0, got_q[0]}, 32'h000010);
            check("t3_second", {10'd0, got_q[1]}, 32'h000011);
        end
        check("t3_ok", {31'd0, char_ok}, 32'd1);
        check("t3_data", char_data, mem(22'h000011));

        // Object miss gated by obj_cs
        force_ack = -1;
        force_dok = -1;
        got_q.delete();
        obj_cs   = 1'b0;
        obj_addr = 18'h00033;
        run(10);
        check("t4_no_req", got_q.size(), 0);
        obj_cs = 1'b1;
        run(12);
        check("t4_count", got_q.size(), 1);
        if (got_q.size() == 1) check("t4_addr", {10'd0, got_q[0]}, 32'h024033);
        check("t4_ok", {31'd0, obj_ok}, 32'd1);

        // ack and dok together, back-to-back misses
        force_ack = 0;
        force_dok = 0;
        got_q.delete();
        char_addr = 14'h0005;
        scr_addr  = 17'h00007;
        run(12);
        check("t5_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t5_char", {10'd0, got_q[0]}, 32'h000005);
            check("t5_scr", {10'd0, got_q[1]}, 32'h004007);
        end

        // Reset while a request is outstanding, then a stray dok
        force_ack = 3;
        force_dok = -1;
        char_addr = 14'h0009;
        run_until_phase(1);
        do_reset();
        check("t6_ok_after_rst", {29'd0, char_ok, scr_ok, obj_ok}, 32'd0);
        force_spur = 1'b1;
        advance();
        force_spur = 1'b0;
        check("t6_ok_after_spur", {29'd0, char_ok, scr_ok, obj_ok}, 32'd0);
        force_ack = -1;
        run(20);

        // Random traffic over a small address pool so hits recur
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 3) == 0) char_addr = 14'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) scr_addr  = 17'($urandom_range(0, 3)) | 17'h1FF00;
            if ($urandom_range(0, 5) == 0) obj_addr  = ($urandom_range(0, 1) == 0) ?
                                                       18'($urandom_range(0, 3)) : 18'h3FFFF;
            if ($urandom_range(0, 7) == 0) obj_cs    = ~obj_cs;
            if ($urandom_range(0, 299) == 0) do_reset();
            else                             advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtkunio_gfxrom_arb.md
Name: jtkunio_gfxrom_arb

Overview:
- Graphics ROM arbiter sitting directly upstream of the video stage.
- Serves the three video fetch clients (char, scroll, object) from one shared 32-bit SDRAM read port.
- Holds one cached 32-bit word per client and returns it with an ok flag to the tile and sprite engines.
- Replaces ad-hoc per-layer SDRAM slots in the kunio core.

Parameters:
- CHAR_OFFSET, 22'h00000, SDRAM word offset of the char ROM region.
- SCR_OFFSET, 22'h04000, SDRAM word offset of the scroll ROM region.
- OBJ_OFFSET, 22'h24000, SDRAM word offset of the object ROM region.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- char_addr  in  14  char word address
- char_data  out  32  cached char word
- char_ok  out  1  char_data valid for the current char_addr
- scr_addr  in  17  scroll word address
- scr_data  out  32  cached scroll word
- scr_ok  out  1  scr_data valid for the current scr_addr
- obj_cs  in  1  object fetch enable
- obj_addr  in  18  object word address
- obj_data  out  32  cached object word
- obj_ok  out  1  obj_data valid for the current obj_addr
- sdram_addr  out  22  word address to SDRAM controller
- sdram_req  out  1  read request, held until ack
- sdram_ack  in  1  request accepted (one-cycle pulse)
- sdram_dok  in  1  read data valid (one-cycle pulse)
- sdram_din  in  32  read data

Behaviour:
- Reset (clk edge with rst=1):
  - sdram_req=0, sdram_addr=0, state=IDLE.
  - All cache valid bits=0, all *_data=0.
  - All *_ok=0.
- Per client state: cached address (full client width), valid bit, 32-bit data register.
- Hit rule (combinational):
  - char_ok = valid_c & (char_addr==tag_c).
  - scr_ok = valid_s & (scr_addr==tag_s).
  - obj_ok = obj_cs & valid_o & (obj_addr==tag_o).
  - Consequence: ok falls in the same cycle the address changes.
- Miss:
  - Char and scroll always request on miss.
  - Object requests only when obj_cs=1.
- FSM states:
  - IDLE: if any miss, pick winner by fixed priority char > scr > obj. Latch its address as pending tag and its slot id. Drive sdram_addr = OFFSET + zero-extended addr (22-bit sum, wrap silently). Set sdram_req=1. Go to WAIT_ACK.
  - WAIT_ACK: hold sdram_req and sdram_addr. On sdram_ack, drop sdram_req next cycle and go to WAIT_DATA.
  - WAIT_DATA: on sdram_dok, write sdram_din to the slot's data register, tag = pending tag, valid=1. Return to IDLE.
- The slot's valid bit is cleared when its request is issued, so a stale word is never flagged ok.
- ack and dok in the same cycle: treated as ack followed by immediate data; write the slot and go straight to IDLE.
- Client address changes during a transaction: the fetch completes with the latched tag, and ok stays low because of the tag mismatch. The slot re-requests from IDLE after any higher-priority misses are served.
- obj_cs drops mid-transaction: the transaction completes and the object slot is filled; obj_ok is gated low.
- Latency from miss to ok (zero-wait controller): 1 cycle to issue, plus ack delay, plus dok delay, plus 1 cycle to write the register.
- Back-to-back: minimum one IDLE cycle between transactions.
- Reset asserted mid-transaction: abort the transaction, clear sdram_req, invalidate all slots. Late ack/dok pulses are ignored while in IDLE.

Optional Feature:
- Macro: JTKUNIO_GFXSTATS_EN.
- When defined:
  - Adds outputs stat_char, stat_scr, stat_obj, each 16 bits, counting completed fills per client. Counters saturate at 16'hFFFF.
  - Adds input stat_clr (1 bit), which zeroes all three counters synchronously.
  - Counters are cleared by rst.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then char_addr=14'h0010 with an SDRAM model (ack after 2 cycles, dok 3 cycles later, data 32'hDEADBEEF) -> sdram_addr=22'h000010, then char_data=DEADBEEF and char_ok=1; no second request while the address is held.
- Char, scroll and object miss in the same cycle (scr_addr=17'h00100, obj_addr=18'h00020, obj_cs=1) -> requests issued in order 22'h0000xx (char), 22'h004100, 22'h024020; each ok rises only after its own dok.
- char_addr changes 14'h0010->14'h0011 while in WAIT_DATA -> char_ok stays 0 after the fill; a new request to 22'h000011 is issued, and ok=1 after that fill.
- obj_cs=0 with an object miss -> no SDRAM request; asserting obj_cs=1 -> request to OBJ_OFFSET+obj_addr.
- ack and dok in the same cycle -> slot filled, FSM back in IDLE one cycle later, next request issued the cycle after that.
- rst pulsed while in WAIT_ACK -> sdram_req=0 the following cycle, all ok=0; a spurious dok afterwards does not set any ok.
